// File: rtl/seq_detect_param.sv
// seq_detect_param: runtime-configurable serial pattern detector.
// Watches a valid-qualified bit stream and pulses `detect` one cycle after
// the last `len` accepted bits equal the loaded pattern. Overlapping or
// restart-after-match behaviour is selectable at load time.
// Optional feature macro: SEQDET_MATCH_COUNT_EN builds the saturating
// match counter; without it `match_count` is tied to zero.
module seq_detect_param #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               data_valid,
  input  logic               data_in,
  output logic               detect,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [LEN_W-1:0]   LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]   LEN_RST = LEN_W'(6);
  localparam logic [MAX_LEN-1:0] PAT_RST = MAX_LEN'(6'b101100);

  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   len;
  logic               ovl;
  logic [LEN_W-1:0]   fill;

  logic [LEN_W-1:0]   len_clamp;
  logic [MAX_LEN-1:0] hist_next;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W:0]     fill_p1;
  logic               accept;
  logic               match;

  // Clamp the requested length into 1..MAX_LEN before it becomes active.
  always_comb begin
    len_clamp = cfg_len;
    if (cfg_len == '0) begin
      len_clamp = LEN_W'(1);
    end else if (cfg_len > LEN_MAX) begin
      len_clamp = LEN_MAX;
    end
  end

  // Match evaluation on the post-shift history; bits at or above len are masked off.
  always_comb begin
    accept    = data_valid & ~cfg_load;
    hist_next = {hist[MAX_LEN-2:0], data_in};
    fill_p1   = {1'b0, fill} + (LEN_W+1)'(1);
    mask      = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
    match = accept && (fill_p1 >= {1'b0, len}) && (((hist_next ^ pat) & mask) == '0);
  end

  // Configuration, history, fill level and the registered detect pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      pat    <= PAT_RST;
      len    <= LEN_RST;
      ovl    <= 1'b1;
      hist   <= '0;
      fill   <= '0;
      detect <= 1'b0;
    end else if (cfg_load) begin
      pat    <= cfg_pattern;
      len    <= len_clamp;
      ovl    <= cfg_overlap;
      hist   <= '0;
      fill   <= '0;
      detect <= 1'b0;
    end else begin
      detect <= match;
      if (accept) begin
        hist <= hist_next;
        if (match && !ovl) begin
          fill <= '0;
        end else if (fill != len) begin
          fill <= fill + LEN_W'(1);
        end
      end
    end
  end

`ifdef SEQDET_MATCH_COUNT_EN
  // Saturating match counter; survives cfg_load, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      match_count <= '0;
    end else if (match && (match_count != {CNT_W{1'b1}})) begin
      match_count <= match_count + CNT_W'(1);
    end
  end
`else
  assign match_count = '0;
`endif

endmodule
